// File: rtl/decoder_scan_sequencer_if.sv
// Control/status bundle between a scan controller and decoder_scan_sequencer.
// master drives start/stop/ch_mask; slave (the sequencer) drives the decoder-side outputs.
interface decoder_scan_sequencer_if #(
  parameter int unsigned NUM_OF_BITS = 3
) ();
  localparam int unsigned N = 2 ** NUM_OF_BITS;

  logic                   start;
  logic                   stop;
  logic [N-1:0]           ch_mask;
  logic [NUM_OF_BITS-1:0] a;
  logic                   ena;
  logic                   busy;
  logic                   frame_done;

  modport master (
    output start, stop, ch_mask,
    input  a, ena, busy, frame_done
  );

  modport slave (
    input  start, stop, ch_mask,
    output a, ena, busy, frame_done
  );
endinterface

// File: rtl/decoder_scan_sequencer.sv
// Round-robin scan sequencer driving the select/enable of a 3-to-8 decoder.
// Each enabled channel is held for DWELL_CYCLES, then blanked for BLANK_CYCLES.
module decoder_scan_sequencer #(
  parameter int unsigned NUM_OF_BITS  = 3,
  parameter int unsigned DWELL_CYCLES = 1000,
  parameter int unsigned BLANK_CYCLES = 2
) (
  input logic                     clk,
  input logic                     rst_n,
  decoder_scan_sequencer_if.slave bus
);
  localparam int unsigned N       = 2 ** NUM_OF_BITS;
  localparam int unsigned CntMax  = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int unsigned CntW    = $clog2(CntMax + 1);
  localparam logic [CntW-1:0] DwellLast = CntW'(DWELL_CYCLES);
  localparam logic [CntW-1:0] BlankLast = CntW'(BLANK_CYCLES);
  localparam logic [CntW-1:0] CntOne    = CntW'(1);
  localparam logic            NoBlank   = (BLANK_CYCLES == 0);

  typedef enum logic [1:0] {StIdle, StDwell, StBlank} state_e;

  state_e                 state_q;
  logic [CntW-1:0]        cnt_q;
  logic                   stop_pending_q;
  logic [NUM_OF_BITS-1:0] a_q;
  logic                   ena_q;
  logic                   busy_q;
  logic                   frame_done_q;

  logic                   mask_any;
  logic [NUM_OF_BITS-1:0] lowest_ch;
  logic [NUM_OF_BITS-1:0] next_ch;
  logic                   next_found;
  logic                   dwell_end;
  logic                   blank_end;
  logic                   advance;
  logic                   adv_idle;
  logic [NUM_OF_BITS-1:0] adv_a;
  logic                   adv_wrap;

  assign mask_any = |bus.ch_mask;

  // Descending scan leaves the lowest set bit, and the lowest set bit above a_q.
  always_comb begin
    lowest_ch  = '0;
    next_ch    = '0;
    next_found = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (bus.ch_mask[i]) begin
        lowest_ch = NUM_OF_BITS'(i);
        if (i > int'(a_q)) begin
          next_ch    = NUM_OF_BITS'(i);
          next_found = 1'b1;
        end
      end
    end
  end

  always_comb begin
    dwell_end = (state_q == StDwell) && (cnt_q == DwellLast);
    blank_end = (state_q == StBlank) && (cnt_q == BlankLast);
    advance   = (dwell_end && NoBlank) || blank_end;
    // A stop arriving on the advance edge itself still wins over the next channel.
    adv_idle  = bus.stop || stop_pending_q || !mask_any;
    adv_a     = next_found ? next_ch : lowest_ch;
    adv_wrap  = !next_found;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      cnt_q          <= '0;
      stop_pending_q <= 1'b0;
      a_q            <= '0;
      ena_q          <= 1'b0;
      busy_q         <= 1'b0;
      frame_done_q   <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          stop_pending_q <= 1'b0;
          ena_q          <= 1'b0;
          busy_q         <= 1'b0;
          if (bus.start && !bus.stop && mask_any) begin
            state_q <= StDwell;
            a_q     <= lowest_ch;
            ena_q   <= 1'b1;
            busy_q  <= 1'b1;
            cnt_q   <= CntOne;
          end
        end
        StDwell, StBlank: begin
          if (bus.stop) begin
            stop_pending_q <= 1'b1;
          end
          if (advance) begin
            stop_pending_q <= 1'b0;
            if (adv_idle) begin
              state_q <= StIdle;
              ena_q   <= 1'b0;
              busy_q  <= 1'b0;
              cnt_q   <= '0;
            end else begin
              state_q      <= StDwell;
              a_q          <= adv_a;
              ena_q        <= 1'b1;
              frame_done_q <= adv_wrap;
              cnt_q        <= CntOne;
            end
          end else if (dwell_end) begin
            state_q <= StBlank;
            ena_q   <= 1'b0;
            cnt_q   <= CntOne;
          end else begin
            cnt_q <= cnt_q + CntOne;
          end
        end
        default: begin
          state_q <= StIdle;
          ena_q   <= 1'b0;
          busy_q  <= 1'b0;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign bus.a          = a_q;
  assign bus.ena        = ena_q;
  assign bus.busy       = busy_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_decoder_scan_sequencer.sv
// Self-checking bench: a slot-position model of the scan is compared every cycle,
// plus directed scenarios with hand-computed expectations and a randomized phase.
module tb_decoder_scan_sequencer;
  localparam int D = 3;
  localparam int B = 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  decoder_scan_sequencer_if #(.NUM_OF_BITS(3)) bus ();

  decoder_scan_sequencer #(
    .NUM_OF_BITS (3),
    .DWELL_CYCLES(D),
    .BLANK_CYCLES(B)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  // Model: each channel occupies a slot of D+B cycles; m_pos is the position in the slot.
  int m_active = 0;
  int m_ch     = 0;
  int m_pos    = 0;
  int m_fd     = 0;
  int m_pend   = 0;

  function automatic int lowest(input logic [7:0] m);
    for (int i = 0; i < 8; i++) if (m[i]) return i;
    return -1;
  endfunction

  function automatic int next_above(input logic [7:0] m, input int c);
    for (int i = c + 1; i < 8; i++) if (m[i]) return i;
    return -1;
  endfunction

  task automatic model_step();
    int nx;
    if (!rst_n) begin
      m_active = 0; m_ch = 0; m_pos = 0; m_fd = 0; m_pend = 0;
    end else begin
      m_fd = 0;
      if (m_active == 0) begin
        m_pend = 0;
        if (bus.start && !bus.stop && bus.ch_mask != 0) begin
          m_active = 1;
          m_ch     = lowest(bus.ch_mask);
          m_pos    = 0;
        end
      end else begin
        if (bus.stop) m_pend = 1;
        if (m_pos == D + B - 1) begin
          if (m_pend != 0 || bus.ch_mask == 0) begin
            m_active = 0;
            m_pend   = 0;
          end else begin
            nx = next_above(bus.ch_mask, m_ch);
            if (nx < 0) begin
              nx   = lowest(bus.ch_mask);
              m_fd = 1;
            end
            m_ch  = nx;
            m_pos = 0;
          end
        end else begin
          m_pos++;
        end
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      model_step();
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One cycle: wait for the falling edge, compare every output against the model.
  task automatic tick();
    @(negedge clk);
    check("a", int'(bus.a), m_ch);
    check("ena", int'(bus.ena), (m_active != 0 && m_pos < D) ? 1 : 0);
    check("busy", int'(bus.busy), m_active);
    check("frame_done", int'(bus.frame_done), m_fd);
  endtask

  task automatic go_idle();
    bit ok = 0;
    bus.stop = 1'b1;
    for (int k = 0; k < 40 && !ok; k++) begin
      tick();
      if (!bus.busy) ok = 1;
    end
    bus.stop = 1'b0;
    check("go_idle", int'(ok), 1);
  endtask

  task automatic wait_sel(input int ch, input string name);
    bit ok = 0;
    for (int k = 0; k < 40 && !ok; k++) begin
      tick();
      if (int'(bus.a) == ch && bus.ena) ok = 1;
    end
    check(name, int'(ok), 1);
  endtask

  initial begin
    int first_fd;
    int rises;
    int order_err;
    int prev;
    int n;
    int fd4;
    int forbidden;
    int ena_cnt;
    int fd_seen;
    int blank_busy;
    int seq[4];

    bus.start   = 1'b0;
    bus.stop    = 1'b0;
    bus.ch_mask = 8'h00;

    // 1. Reset then idle
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (20) tick();
    check("t1_a", int'(bus.a), 0);
    check("t1_ena", int'(bus.ena), 0);
    check("t1_busy", int'(bus.busy), 0);

    // 2. Full scan
    bus.ch_mask = 8'hFF;
    bus.start   = 1'b1;
    tick();
    bus.start = 1'b0;
    first_fd  = -1;
    rises     = 1;
    order_err = 0;
    prev      = 1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (bus.frame_done && first_fd < 0) begin
        first_fd = i;
        check("t2_wrap_a", int'(bus.a), 0);
      end
      if (first_fd < 0 && bus.ena && prev == 0) begin
        if (int'(bus.a) != rises) order_err++;
        rises++;
      end
      prev = int'(bus.ena);
    end
    check("t2_fd_latency", first_fd, 32);
    check("t2_channels", rises, 8);
    check("t2_order", order_err, 0);
    go_idle();

    // 3. Sparse mask
    bus.ch_mask = 8'b1010_0100;
    bus.start   = 1'b1;
    tick();
    bus.start = 1'b0;
    prev = 0; n = 0; fd4 = 0; forbidden = 0;
    for (int i = 0; i < 4; i++) seq[i] = -1;
    for (int k = 0; k < 40 && n < 4; k++) begin
      if (bus.ena && prev == 0) begin
        seq[n] = int'(bus.a);
        if (n == 3) fd4 = int'(bus.frame_done);
        n++;
      end
      if (bus.ena && (bus.a inside {3'd0, 3'd1, 3'd3, 3'd4, 3'd6})) forbidden++;
      prev = int'(bus.ena);
      if (n < 4) tick();
    end
    check("t3_seq0", seq[0], 2);
    check("t3_seq1", seq[1], 5);
    check("t3_seq2", seq[2], 7);
    check("t3_seq3", seq[3], 2);
    check("t3_fd_on_wrap", fd4, 1);
    check("t3_forbidden", forbidden, 0);
    go_idle();

    // 4. Stop during the second dwell cycle of channel 3
    bus.ch_mask = 8'hFF;
    bus.start   = 1'b1;
    tick();
    bus.start = 1'b0;
    wait_sel(3, "t4_reach_ch3");
    ena_cnt = 1; fd_seen = 0; blank_busy = 0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (k == 1) bus.stop = 1'b1;
      if (k == 2) bus.stop = 1'b0;
      if (bus.ena && bus.a == 3'd3) ena_cnt++;
      if (bus.frame_done) fd_seen++;
      if (k == 3) blank_busy = int'(bus.busy) * 2 + int'(bus.ena);
    end
    check("t4_dwell_len", ena_cnt, 3);
    check("t4_blank_busy_ena", blank_busy, 2);
    check("t4_idle_busy", int'(bus.busy), 0);
    check("t4_no_fd", fd_seen, 0);

    // 5a. Start with an empty mask is ignored
    bus.ch_mask = 8'h00;
    bus.start   = 1'b1;
    repeat (5) tick();
    bus.start = 1'b0;
    check("t5_empty_start", int'(bus.busy), 0);

    // 5b. Mask cleared during the dwell of channel 4
    bus.ch_mask = 8'hFF;
    bus.start   = 1'b1;
    tick();
    bus.start = 1'b0;
    wait_sel(4, "t5_reach_ch4");
    bus.ch_mask = 8'h00;
    blank_busy  = 0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (k == 3) blank_busy = int'(bus.busy) * 2 + int'(bus.ena);
    end
    check("t5_blank_busy_ena", blank_busy, 2);
    check("t5_idle_busy", int'(bus.busy), 0);

    // 6. Asynchronous reset mid-dwell
    bus.ch_mask = 8'hFF;
    bus.start   = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (5) tick();
    check("t6_pre_a", int'(bus.a), 1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_async_ena", int'(bus.ena), 0);
    check("t6_async_a", int'(bus.a), 0);
    check("t6_async_busy", int'(bus.busy), 0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (5) tick();
    check("t6_no_resume", int'(bus.busy), 0);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("t6_restart", int'(bus.busy), 1);

    // Randomized traffic checked by the model every cycle
    for (int k = 0; k < 2500; k++) begin
      tick();
      bus.start = ($urandom_range(3) == 0);
      bus.stop  = ($urandom_range(47) == 0);
      if ($urandom_range(23) == 0) begin
        bus.ch_mask = ($urandom_range(5) == 0) ? 8'h00 : 8'($urandom);
      end
    end
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    repeat (2) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
